mips_shift_pipe: RTL and testbench
==================================

# mips_shift_pipe

Parametrised, pipelined logarithmic barrel shifter for the MIPS datapath. It generalises the 8-bit four-way shift select to a WIDTH-bit operand with six shift modes, one pipeline stage per shift-amount bit, and a valid/ready handshake on both sides. It sits between the ID/EX operand latches and the EX result mux, and accepts one operation per cycle under no back-pressure.

## Interface
Parameters:
- WIDTH, 32: data width; power of two, 8 to 64.
- TAG_W, 4: width of the opaque tag that travels with each operation.
- SHW (localparam), $clog2(WIDTH): shift-amount width, and also the pipeline depth.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_op  in  3  mode, see Operation.
- in_shamt  in  SHW  shift amount.
- in_data  in  WIDTH  operand.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of this result.
- out_zero  out  1  out_data == 0.
- out_err  out  1  in_op was an undefined code.

## Operation
- Op codes:
  - 000 PASS
  - 001 SLL, zero fill
  - 010 SRL, zero fill
  - 011 SRA, fill with operand MSB
  - 100 ROR
  - 101 ROL
  - 110/111 undefined: data passes unshifted and out_err=1.
- Stage k (k = 0..SHW-1) shifts or rotates by 2^k when shamt[k]=1; otherwise it passes data through.
- Each stage register holds:
  - valid
  - data
  - op
  - remaining shamt bits
  - tag
  - err
  - sign (SRA fill bit, captured from in_data[WIDTH-1] at acceptance)
- Stage k advances when it is empty or the stage downstream of it advances. The downstream of the last stage is out_ready.
- in_ready = stage-0 advance condition. It is combinational from out_ready through the chain; there is no skid buffer.
- out_* are driven directly from the last stage register.
- shamt 0, and PASS/undefined ops: data is bit-exact to the input.
- SRA with sign=0 is identical to SRL.
- Rotates by any amount preserve popcount.
- out_zero is computed from the final stage data, registered alongside it.

## Timing
- Latency: SHW cycles from acceptance to out_valid, when no stall occurs. WIDTH=32 gives 5 cycles.
- Throughput: one operation per cycle while out_ready=1.
- Stall: with out_ready=0 and out_valid=1, all out_* hold stable.
  - Bubbles upstream still compress.
  - in_ready drops only when every stage is full.
- Simultaneous accept and drain on a full pipe: permitted in the same cycle, no bubble inserted.
- Reset: on a rst=1 clock edge, every stage valid is cleared and every stage data/tag/err/zero register is cleared to 0.
  - Hence out_valid=0, out_data=0, out_tag=0, out_zero=0, out_err=0.
  - in_ready=1 in the cycle after reset.
  - Reset asserted mid-stream discards all in-flight operations; none is emitted.
- In-order: results leave in acceptance order. Tags are never reordered or duplicated.

## Structure
- Package mips_shift_pkg holds:
  - the op code localparams or enum (OP_PASS, OP_SLL, OP_SRL, OP_SRA, OP_ROR, OP_ROL)
  - the stage payload struct (data, op, shamt, tag, err, sign), parametrised by width through the module.
- Sub-module mips_shift_stage, parameter K: one register stage that applies the 2^K shift and runs the local valid/advance logic. mips_shift_pipe generates SHW instances of it.

## Test plan
- WIDTH=32, out_ready=1. Accept SLL, data 0x0000_0001, shamt 31, tag 3.
  - out_valid rises exactly 5 cycles later with out_data 0x8000_0000, out_tag 3, out_zero 0.
- SRA, data 0x8000_0000, shamt 4 -> 0xF800_0000. The same operand with SRL -> 0x0800_0000.
- ROR 0x1234_5678 by 8 -> 0x7812_3456. ROL 0x1234_5678 by 8 -> 0x3456_7812.
- Op 111, data 0xDEAD_BEEF, shamt 7 -> out_data 0xDEAD_BEEF, out_err 1. SLL 0x1 by 0 -> 0x1.
- Issue 10 back-to-back ops, tags 0..9, with out_ready held 0 from cycle 3 to cycle 12.
  - in_ready falls once 5 ops are held.
  - out_* stay stable during the stall.
  - All 10 tags emerge in order with no loss or duplicate.
- Assert rst for one cycle with 3 ops in flight.
  - Next cycle: out_valid 0, out_data 0, in_ready 1.
  - None of the 3 flushed tags ever appears at the output.

Source files
------------

// File: rtl/mips_shift_pkg.sv
// Shared types for the pipelined MIPS barrel shifter: op codes, per-stage
// control payload and the undefined-op decode.
package mips_shift_pkg;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_SLL  = 3'b001,
        OP_SRL  = 3'b010,
        OP_SRA  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ROL  = 3'b101
    } op_e;

    // Width-independent part of the stage payload; data, shamt and tag are sized by the module.
    typedef struct packed {
        op_e  op;
        logic err;
        logic sign;
    } ctrl_t;

    function automatic logic op_undefined(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/mips_shift_pipe_if.sv
// Valid/ready operand and result bus of the pipelined barrel shifter.
interface mips_shift_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [SHW-1:0]   in_shamt;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_op, in_shamt, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_op, in_shamt, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_err
    );

endinterface

// File: rtl/mips_shift_stage.sv
// One register stage of the log shifter: applies a 2^K shift/rotate when
// shamt[K] is set and runs the local valid/advance handshake.
module mips_shift_stage
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int K     = 0,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [TAG_W-1:0] tag_i,
    input  ctrl_t            ctrl_i,
    input  logic             dn_adv_i,
    output logic             adv_o,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o,
    output logic [SHW-1:0]   shamt_o,
    output logic [TAG_W-1:0] tag_o,
    output ctrl_t            ctrl_o,
    output logic             zero_o
);
    localparam int S = 1 << K;

    function automatic logic [WIDTH-1:0] shift_step(input op_e op, input logic sign,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            OP_SLL:  r = d << S;
            OP_SRL:  r = d >> S;
            // Fill comes from the captured operand sign, not the current MSB.
            OP_SRA:  r = {{S{sign}}, d[WIDTH-1:S]};
            OP_ROR:  r = {d[S-1:0], d[WIDTH-1:S]};
            OP_ROL:  r = {d[WIDTH-S-1:0], d[WIDTH-1:WIDTH-S]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SHW-1:0]   shamt_q;
    logic [TAG_W-1:0] tag_q;
    ctrl_t            ctrl_q;
    logic             zero_q;

    assign data_d = shamt_i[K] ? shift_step(ctrl_i.op, ctrl_i.sign, data_i) : data_i;
    assign adv_o  = !vld_q || dn_adv_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            tag_q   <= '0;
            ctrl_q  <= '0;
            zero_q  <= 1'b0;
        end else if (adv_o) begin
            vld_q <= vld_i;
            if (vld_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                tag_q   <= tag_i;
                ctrl_q  <= ctrl_i;
                zero_q  <= (data_d == '0);
            end
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign tag_o   = tag_q;
    assign ctrl_o  = ctrl_q;
    assign zero_o  = zero_q;

endmodule

// File: rtl/mips_shift_pipe.sv
// Pipelined logarithmic barrel shifter: SHW chained shift stages with
// valid/ready back-pressure rippling from out_ready to in_ready.
module mips_shift_pipe
    import mips_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic              clk,
    input logic              rst,
    mips_shift_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    // Index k is the input of stage k; index SHW is the last stage register.
    logic [SHW:0]     vld_s;
    logic [SHW:0]     adv_s;
    logic [WIDTH-1:0] data_s  [SHW+1];
    logic [SHW-1:0]   shamt_s [SHW+1];
    logic [TAG_W-1:0] tag_s   [SHW+1];
    ctrl_t            ctrl_s  [SHW+1];
    logic [SHW:1]     zero_s;

    assign vld_s[0]   = bus.in_valid;
    assign data_s[0]  = bus.in_data;
    assign shamt_s[0] = bus.in_shamt;
    assign tag_s[0]   = bus.in_tag;
    assign ctrl_s[0]  = '{op:   op_e'(bus.in_op),
                          err:  op_undefined(bus.in_op),
                          sign: bus.in_data[WIDTH-1]};
    assign adv_s[SHW] = bus.out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        mips_shift_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .K     (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .vld_i    (vld_s[k]),
            .data_i   (data_s[k]),
            .shamt_i  (shamt_s[k]),
            .tag_i    (tag_s[k]),
            .ctrl_i   (ctrl_s[k]),
            .dn_adv_i (adv_s[k+1]),
            .adv_o    (adv_s[k]),
            .vld_o    (vld_s[k+1]),
            .data_o   (data_s[k+1]),
            .shamt_o  (shamt_s[k+1]),
            .tag_o    (tag_s[k+1]),
            .ctrl_o   (ctrl_s[k+1]),
            .zero_o   (zero_s[k+1])
        );
    end

    assign bus.in_ready  = adv_s[0];
    assign bus.out_valid = vld_s[SHW];
    assign bus.out_data  = data_s[SHW];
    assign bus.out_tag   = tag_s[SHW];
    assign bus.out_err   = ctrl_s[SHW].err;
    assign bus.out_zero  = zero_s[SHW];

    // Payload fields that have no consumer past the final stage.
    logic unused_tail;
    assign unused_tail = ^{ctrl_s[SHW].op, ctrl_s[SHW].sign, shamt_s[SHW], zero_s[SHW-1:1]};

endmodule

// File: tb/tb_mips_shift_pipe.sv
// Scoreboard bench for mips_shift_pipe: directed ops, stall, and mid-stream reset.
module tb_mips_shift_pipe;
    import mips_shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             zero;
        int               issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_shift_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    mips_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   accepted  = 0;
    int   popped    = 0;
    int   stall_lo  = -1;
    int   stall_hi  = -1;
    bit   mon_en    = 1'b0;
    bit   rdy_low_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input int sh, input logic [WIDTH-1:0] d,
                         input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp,
                         input logic err, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_shamt = sh[SHW-1:0];
        bus.in_data  = d;
        bus.in_tag   = tag;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.data  = exp;
                e.tag   = tag;
                e.err   = err;
                e.zero  = (exp == '0);
                e.issue = lat ? cyc : -1;
                sb.push_back(e);
                accepted++;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: tag %0d never accepted within 100 cycles", tag);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                if (bus.in_valid && !bus.in_ready) begin
                    rdy_low_seen = 1'b1;
                    chk("in_ready_low_occupancy", accepted - popped, SHW);
                end
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got tag %0d data %0h, expected no output",
                                 bus.out_tag, bus.out_data);
                    end else begin
                        chk("out_data", bus.out_data, sb[0].data);
                        chk("out_tag", bus.out_tag, sb[0].tag);
                        chk("out_err", bus.out_err, sb[0].err);
                        chk("out_zero", bus.out_zero, sb[0].zero);
                        if (bus.out_ready) begin
                            if (sb[0].issue >= 0) chk("latency", cyc - sb[0].issue, SHW);
                            void'(sb.pop_front());
                            popped++;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_shamt  = '0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_tag", bus.out_tag, 0);
        chk("rst_out_zero", bus.out_zero, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        mon_en = 1'b1;

        // Single op on an empty pipe, latency measured
        do_op(3'b001, 31, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b0, 1'b1);
        idle(8);

        // Directed vectors, back to back
        do_op(3'b011,  4, 32'h8000_0000, 4'd1,  32'hF800_0000, 1'b0, 1'b0);
        do_op(3'b010,  4, 32'h8000_0000, 4'd2,  32'h0800_0000, 1'b0, 1'b0);
        do_op(3'b100,  8, 32'h1234_5678, 4'd4,  32'h7812_3456, 1'b0, 1'b0);
        do_op(3'b101,  8, 32'h1234_5678, 4'd5,  32'h3456_7812, 1'b0, 1'b0);
        do_op(3'b111,  7, 32'hDEAD_BEEF, 4'd6,  32'hDEAD_BEEF, 1'b1, 1'b0);
        do_op(3'b001,  0, 32'h0000_0001, 4'd7,  32'h0000_0001, 1'b0, 1'b0);
        do_op(3'b000,  3, 32'h0000_0000, 4'd8,  32'h0000_0000, 1'b0, 1'b0);
        do_op(3'b010, 31, 32'hFFFF_FFFF, 4'd9,  32'h0000_0001, 1'b0, 1'b0);
        do_op(3'b011, 31, 32'h7FFF_FFFF, 4'd10, 32'h0000_0000, 1'b0, 1'b0);
        do_op(3'b101,  1, 32'h8000_0001, 4'd11, 32'h0000_0003, 1'b0, 1'b0);
        do_op(3'b001,  4, 32'hF000_000F, 4'd12, 32'h0000_00F0, 1'b0, 1'b0);
        do_op(3'b110,  5, 32'h0000_0000, 4'd13, 32'h0000_0000, 1'b1, 1'b0);
        do_op(3'b011,  5, 32'hC000_0000, 4'd14, 32'hFE00_0000, 1'b0, 1'b0);
        do_op(3'b100,  1, 32'h0000_0001, 4'd15, 32'h8000_0000, 1'b0, 1'b0);
        idle(10);

        // Ten back-to-back ops with out_ready low for relative cycles 3..12
        stall_lo = cyc + 1 + 3;
        stall_hi = cyc + 1 + 12;
        for (int t = 0; t < 10; t++)
            do_op(3'b001, 4, t, t[TAG_W-1:0], t * 16, 1'b0, 1'b0);
        idle(25);
        chk("stall_in_ready_dropped", rdy_low_seen, 1);
        chk("stall_all_drained", popped, accepted);
        stall_lo = -1;
        stall_hi = -1;

        // Three ops in flight, then a one-cycle reset flushes them
        do_op(3'b010, 1, 32'h0000_0010, 4'd10, 32'h0000_0008, 1'b0, 1'b0);
        do_op(3'b010, 1, 32'h0000_0020, 4'd11, 32'h0000_0010, 1'b0, 1'b0);
        do_op(3'b010, 1, 32'h0000_0040, 4'd12, 32'h0000_0020, 1'b0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        accepted = popped;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus.out_valid, 0);
        chk("flush_out_data", bus.out_data, 0);
        chk("flush_in_ready", bus.in_ready, 1);
        idle(12);

        // Pipe still works after the flush
        do_op(3'b101, 4, 32'h8000_0000, 4'd9, 32'h0000_0008, 1'b0, 1'b1);
        idle(10);
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
